// File: rtl/modulo_lut_reduce.sv
// modulo_lut_reduce: pipelined LUT-based modular reducer with registered adder tree and multi-beat accumulator
module modulo_lut_reduce #(
  parameter int MODULUS = 13,
  parameter int MODBITWIDTH = 4,
  parameter int NUMBITS = 12,
  parameter int BASEPOW = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [NUMBITS-1:0]     in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  output logic [MODBITWIDTH-1:0] value_out
);
  localparam int W = MODBITWIDTH;
  localparam int G = (NUMBITS + 5) / 6;
  localparam int LEVELS = $clog2(G);
  localparam int PW = 6 * G;
  localparam logic [W:0] MW = (W+1)'(MODULUS);

  if (MODULUS < 2 || 64'(MODULUS) >= (64'd1 << MODBITWIDTH) || NUMBITS < 1) begin : g_bad_params
    $error("modulo_lut_reduce: MODULUS must be in [2, 2^MODBITWIDTH) and NUMBITS >= 1");
  end

  function automatic longint entry(int g, int x);
    longint p, s;
    p = 1 % MODULUS;
    s = 0;
    for (int i = 0; i < BASEPOW + 6 * g; i++) p = (p * 2) % MODULUS;
    for (int b = 0; b < 6; b++) begin
      if (x[b] && 6 * g + b < NUMBITS) s = (s + p) % MODULUS;
      p = (p * 2) % MODULUS;
    end
    return s;
  endfunction

  function automatic logic [W-1:0] add_mod(logic [W-1:0] a, logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= MW ? W'(s - MW) : W'(s);
  endfunction

  function automatic int cnt(int k);
    return (G + (1 << k) - 1) >> k;
  endfunction

  typedef enum logic {IDLE, ACCUM} state_t;

  logic [PW-1:0] padded;
  logic [W-1:0]  lut [G][64];
  logic [W-1:0]  node [LEVELS+1][G];
  logic [LEVELS:0] vld, lst;
  logic [W-1:0]  acc, beat, sum;
  logic          bv, bl;
  state_t        state, state_nx;

  assign padded = PW'(in_data);

  for (genvar g = 0; g < G; g++) begin : g_tbl
    for (genvar x = 0; x < 64; x++) begin : g_ent
      assign lut[g][x] = W'(entry(g, x));
    end
  end

  // Level 0 holds the table residues; each later level halves the count, odd tail passes through.
  always_ff @(posedge clk) begin
    for (int g = 0; g < G; g++) node[0][g] <= lut[g][padded[6*g +: 6]];
    for (int k = 1; k <= LEVELS; k++)
      for (int i = 0; i < G; i++)
        node[k][i] <= (2*i+1 < cnt(k-1)) ? add_mod(node[k-1][2*i], node[k-1][(2*i+1 < G) ? 2*i+1 : 0])
                    : (2*i < cnt(k-1)) ? node[k-1][2*i] : '0;
    vld[0] <= in_valid & ~reset;
    lst[0] <= in_last;
    for (int k = 1; k <= LEVELS; k++) begin
      vld[k] <= vld[k-1] & ~reset;
      lst[k] <= lst[k-1];
    end
  end

  assign beat = node[LEVELS][0];
  assign bv   = vld[LEVELS];
  assign bl   = lst[LEVELS];
  assign sum  = state == ACCUM ? add_mod(acc, beat) : beat;

  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;

  always_comb state_nx = !bv ? state : bl ? IDLE : ACCUM;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      value_out <= '0;
      acc       <= '0;
    end else begin
      out_valid <= bv & bl;
      if (bv & bl) value_out <= sum;
      if (bv) acc <= bl ? '0 : sum;
    end
  end
endmodule

// File: tb/tb_modulo_lut_reduce.sv
// tb_modulo_lut_reduce: scoreboard bench driving four parameter variants from one stimulus stream
module tb_modulo_lut_reduce;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_last = 1'b0;
  logic [11:0] d12 = '0;
  logic [12:0] d13 = '0;
  logic [63:0] d64 = '0;
  logic        ov_a, ov_b, ov_c, ov_d;
  logic [3:0]  vo_a, vo_b, vo_d;
  logic [7:0]  vo_c;
  int          cyc = 0, n_checks = 0, n_fail = 0;
  logic        rst_q = 1'b0;

  typedef struct {longint val; int due;} exp_t;
  exp_t q [4][$];
  longint unsigned acc [4] = '{0, 0, 0, 0};
  longint unsigned last [4] = '{0, 0, 0, 0};
  longint unsigned mods [4] = '{13, 13, 255, 13};
  int bps [4] = '{0, 4, 3, 0};
  int lat [4] = '{3, 3, 6, 4};

  modulo_lut_reduce #(.MODULUS(13), .MODBITWIDTH(4), .NUMBITS(12), .BASEPOW(0)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(d12), .in_last(in_last),
    .out_valid(ov_a), .value_out(vo_a));
  modulo_lut_reduce #(.MODULUS(13), .MODBITWIDTH(4), .NUMBITS(12), .BASEPOW(4)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(d12), .in_last(in_last),
    .out_valid(ov_b), .value_out(vo_b));
  modulo_lut_reduce #(.MODULUS(255), .MODBITWIDTH(8), .NUMBITS(64), .BASEPOW(3)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(d64), .in_last(in_last),
    .out_valid(ov_c), .value_out(vo_c));
  modulo_lut_reduce #(.MODULUS(13), .MODBITWIDTH(4), .NUMBITS(13), .BASEPOW(0)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(d13), .in_last(in_last),
    .out_valid(ov_d), .value_out(vo_d));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= reset;
  end

  // Reference: a beat's contribution is (data * 2^BASEPOW) mod M, computed directly on the integer.
  function automatic longint unsigned residue(int i, longint unsigned data);
    longint unsigned p = 1;
    for (int k = 0; k < bps[i]; k++) p = (p * 2) % mods[i];
    return ((data % mods[i]) * p) % mods[i];
  endfunction

  task automatic fail(string what, logic [63:0] got, logic [63:0] want);
    n_fail++;
    $display("FAIL %s: got %0d expected %0d at cycle %0d", what, got, want, cyc);
  endtask

  task automatic check(string what, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) fail(what, got, want);
  endtask

  task automatic beat(logic v, logic l, logic [63:0] data);
    longint unsigned dv [4];
    d12 = data[11:0];
    d13 = data[12:0];
    d64 = data;
    in_valid = v;
    in_last = l;
    dv = '{64'(data[11:0]), 64'(data[11:0]), data, 64'(data[12:0])};
    if (v && !reset)
      for (int i = 0; i < 4; i++) begin
        acc[i] = (acc[i] + residue(i, dv[i])) % mods[i];
        if (l) begin
          q[i].push_back('{val: longint'(acc[i]), due: cyc + lat[i]});
          acc[i] = 0;
        end
      end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) beat(1'b0, 1'b0, 64'd0);
  endtask

  task automatic flush_model();
    for (int i = 0; i < 4; i++) begin
      acc[i] = 0;
      q[i].delete();
    end
  endtask

  task automatic mon(int i, logic ov, logic [7:0] vo);
    exp_t e;
    if (rst_q) begin
      check($sformatf("reset_out_valid[%0d]", i), 64'(ov), 64'd0);
      check($sformatf("reset_value_out[%0d]", i), 64'(vo), 64'd0);
      last[i] = 0;
    end else if (ov === 1'b1) begin
      if (q[i].size() == 0) begin
        n_checks++;
        fail($sformatf("unexpected_pulse[%0d]", i), 64'(vo), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = q[i].pop_front();
        check($sformatf("value[%0d]", i), 64'(vo), 64'(e.val));
        check($sformatf("latency[%0d]", i), 64'(cyc), 64'(e.due));
      end
      last[i] = 64'(vo);
    end else begin
      check($sformatf("out_valid_low[%0d]", i), 64'(ov), 64'd0);
      check($sformatf("hold[%0d]", i), 64'(vo), last[i]);
      if (q[i].size() > 0 && q[i][0].due < cyc) begin
        n_checks++;
        fail($sformatf("missing_pulse[%0d]", i), 64'(cyc), 64'(q[i][0].due));
        void'(q[i].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, ov_a, 8'(vo_a));
    mon(1, ov_b, 8'(vo_b));
    mon(2, ov_c, vo_c);
    mon(3, ov_d, 8'(vo_d));
  end

  initial begin
    logic [63:0] data;
    logic v, l;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    beat(1, 1, 64'h00C);
    beat(1, 1, 64'h00D);
    beat(1, 1, 64'hFFF);
    beat(1, 0, 64'h00C);
    beat(1, 1, 64'h005);
    idle(3);
    beat(1, 1, 64'h001);
    beat(1, 0, 64'h00C);
    idle(3);
    beat(1, 1, 64'h005);
    for (int k = 1; k <= 4; k++) beat(1, 1, 64'(k));
    beat(1, 1, 64'h001);
    beat(1, 1, 64'h800);
    beat(1, 1, 64'hFFFF_FFFF_FFFF_FFFF);
    beat(1, 0, 64'h00B);
    beat(1, 1, 64'h00C);
    idle(10);
    beat(1, 0, 64'd7);
    reset = 1'b1;
    flush_model();
    beat(1, 1, 64'd9);
    beat(0, 0, 64'd0);
    reset = 1'b0;
    beat(1, 1, 64'd5);
    idle(10);
    for (int n = 0; n < 10000; n++) begin
      v = $urandom_range(9) < 7;
      l = $urandom_range(3) == 0;
      data = {$urandom, $urandom};
      if ($urandom_range(7) == 0) data = '1;
      beat(v, l, data);
    end
    beat(1, 1, 64'd0);
    idle(12);
    for (int i = 0; i < 4; i++) check($sformatf("queue_drained[%0d]", i), 64'(q[i].size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
